pipe_stage_skid: RTL

Generic parametrised pipeline stage register for inter-stage boundaries (IF/ID … MEM/WB) of the pipelined CPU. It replaces the single-stall-bit latch with a valid/ready handshake, flush, and a one-entry skid buffer, so `in_ready` is a pure register output.
- Data is split into a control field (write enables) and a payload field.
- The control field is forced to zero whenever the output is not valid, so a bubble can never write the register file or CP0.

---
 rtl/pipe_stage_skid.sv | 159 +++++++++++++++
 1 files changed

// File: rtl/pipe_stage_skid.sv
// pipe_stage_skid: valid/ready pipeline register with a one-entry skid
// buffer, flush, and bubble gating of the control field.
// Ports: clk, reset (sync, active-high), flush; in_valid/in_ready/in_ctrl/
// in_data upstream; out_valid/out_ready/out_ctrl/out_data downstream;
// occupancy (0..2); stall_cycles/bubble_cycles statistics.
// Optional statistics counters: define PIPE_STAGE_STATS_EN.
module pipe_stage_skid #(
    parameter int CTRL_W        = 8,
    parameter int DATA_W        = 112,
    parameter bit RESET_PAYLOAD = 1'b1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [CTRL_W-1:0] in_ctrl,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [DATA_W-1:0] out_data,
    output logic [1:0]        occupancy,
    output logic [31:0]       stall_cycles,
    output logic [31:0]       bubble_cycles
);

    typedef enum logic [1:0] {
        S_EMPTY = 2'd0,
        S_HALF  = 2'd1,
        S_FULL  = 2'd3
    } state_e;

    state_e state_q, state_d;

    logic [CTRL_W-1:0] main_ctrl_q, main_ctrl_d;
    logic [CTRL_W-1:0] skid_ctrl_q, skid_ctrl_d;
    logic [DATA_W-1:0] main_data_q, main_data_d;
    logic [DATA_W-1:0] skid_data_q, skid_data_d;

    logic main_v;
    logic skid_v;
    logic accept;
    logic drain;

    // State encoding doubles as the two entry-valid bits.
    assign main_v = state_q[0];
    assign skid_v = state_q[1];

    assign in_ready  = !skid_v;
    assign out_valid = main_v;
    assign out_ctrl  = main_v ? main_ctrl_q : '0;
    assign out_data  = main_data_q;
    assign occupancy = {1'b0, main_v} + {1'b0, skid_v};

    assign accept = in_valid && in_ready;
    assign drain  = main_v && out_ready;

    always_comb begin
        state_d     = state_q;
        main_ctrl_d = main_ctrl_q;
        main_data_d = main_data_q;
        skid_ctrl_d = skid_ctrl_q;
        skid_data_d = skid_data_q;

        unique case (state_q)
            S_EMPTY: begin
                if (accept) begin
                    main_ctrl_d = in_ctrl;
                    main_data_d = in_data;
                    state_d     = S_HALF;
                end
            end
            S_HALF: begin
                unique case (1'b1)
                    drain && accept: begin
                        main_ctrl_d = in_ctrl;
                        main_data_d = in_data;
                    end
                    drain && !accept: begin
                        main_ctrl_d = '0;
                        state_d     = S_EMPTY;
                    end
                    !drain && accept: begin
                        skid_ctrl_d = in_ctrl;
                        skid_data_d = in_data;
                        state_d     = S_FULL;
                    end
                    default: ;
                endcase
            end
            S_FULL: begin
                // in_ready is low here, so only a drain can move data.
                if (drain) begin
                    main_ctrl_d = skid_ctrl_q;
                    main_data_d = skid_data_q;
                    skid_ctrl_d = '0;
                    state_d     = S_HALF;
                end
            end
            default: begin
                state_d = S_EMPTY;
            end
        endcase

        // Reset and flush both discard every entry, including a beat
        // accepted on this same edge.
        if (reset || flush) begin
            state_d     = S_EMPTY;
            main_ctrl_d = '0;
            skid_ctrl_d = '0;
            if (RESET_PAYLOAD) begin
                main_data_d = '0;
                skid_data_d = '0;
            end
        end
    end

    always_ff @(posedge clk) begin
        state_q     <= state_d;
        main_ctrl_q <= main_ctrl_d;
        main_data_q <= main_data_d;
        skid_ctrl_q <= skid_ctrl_d;
        skid_data_q <= skid_data_d;
    end

`ifdef PIPE_STAGE_STATS_EN
    logic [31:0] stall_q, stall_d;
    logic [31:0] bubble_q, bubble_d;

    always_comb begin
        stall_d  = stall_q;
        bubble_d = bubble_q;
        if (reset) begin
            stall_d  = '0;
            bubble_d = '0;
        end else begin
            if (main_v && !out_ready && stall_q != '1) begin
                stall_d = stall_q + 32'd1;
            end
            if (!main_v && bubble_q != '1) begin
                bubble_d = bubble_q + 32'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        stall_q  <= stall_d;
        bubble_q <= bubble_d;
    end

    assign stall_cycles  = stall_q;
    assign bubble_cycles = bubble_q;
`else
    assign stall_cycles  = '0;
    assign bubble_cycles = '0;
`endif

endmodule
